// File: rtl/mrd_cfg_sched_if.sv
// Frame-configuration handshake between the input/top FSM and the DFT size scheduler.
// The slave side is the scheduler; the master side supplies frame events and consumes the configuration.
interface mrd_cfg_sched_if;
  logic        sink_sop;
  logic [11:0] dftpts;
  logic        frame_start;
  logic        cfg_valid;
  logic [2:0]  NumOfFactors;
  logic [17:0] Nf;
  logic [29:0] Nf_PFA;
  logic [9:0]  q_p;
  logic [9:0]  r_p;
  logic        pend_valid;
  logic        unsup_err;
  logic        ovf_err;
  logic        udf_err;

  modport master (
    output sink_sop, dftpts, frame_start,
    input  cfg_valid, NumOfFactors, Nf, Nf_PFA, q_p, r_p,
    input  pend_valid, unsup_err, ovf_err, udf_err
  );

  modport slave (
    input  sink_sop, dftpts, frame_start,
    output cfg_valid, NumOfFactors, Nf, Nf_PFA, q_p, r_p,
    output pend_valid, unsup_err, ovf_err, udf_err
  );
endinterface

// File: rtl/mrd_cfg_sched.sv
// Double-banked DFT size configuration: sink_sop loads a pending bank from the size table,
// frame_start promotes it to the active bank that drives the datapath configuration.
module mrd_cfg_sched (
  input  logic                 clk,
  input  logic                 rst,
  mrd_cfg_sched_if.slave       bus
);

  typedef struct packed {
    logic [2:0]  nof;
    logic [17:0] nf;
    logic [29:0] nf_pfa;
    logic [9:0]  q_p;
    logic [9:0]  r_p;
  } cfg_entry_t;

  // Radix/PFA factors are packed with element [0] in the least significant field.
  localparam cfg_entry_t ENTRY_1200 = '{
    nof:    3'd5,
    nf:     {3'd1, 3'd3, 3'd5, 3'd5, 3'd4, 3'd4},
    nf_pfa: {10'd3, 10'd25, 10'd16},
    q_p:    10'd3,
    r_p:    10'd17
  };
  localparam cfg_entry_t ENTRY_600 = '{
    nof:    3'd5,
    nf:     {3'd1, 3'd3, 3'd5, 3'd5, 3'd2, 3'd4},
    nf_pfa: {10'd3, 10'd25, 10'd8},
    q_p:    10'd2,
    r_p:    10'd67
  };
  localparam cfg_entry_t ENTRY_12 = '{
    nof:    3'd2,
    nf:     {3'd1, 3'd1, 3'd1, 3'd1, 3'd3, 3'd4},
    nf_pfa: {10'd3, 10'd1, 10'd4},
    q_p:    10'd1,
    r_p:    10'd1
  };

  cfg_entry_t active_q, active_d;
  cfg_entry_t pend_q, pend_d;
  logic       cfg_valid_q, cfg_valid_d;
  logic       pend_valid_q, pend_valid_d;
  logic       unsup_err_q, unsup_err_d;
  logic       ovf_err_q, ovf_err_d;
  logic       udf_err_q, udf_err_d;

  cfg_entry_t lut_entry;
  logic       lut_hit;
  logic       load;
  logic       xfer;

  always_comb begin
    lut_entry = ENTRY_1200;
    lut_hit   = 1'b1;
    case (bus.dftpts)
      12'd1200: lut_entry = ENTRY_1200;
      12'd600:  lut_entry = ENTRY_600;
      12'd12:   lut_entry = ENTRY_12;
      default:  lut_hit   = 1'b0;
    endcase
  end

  // A same-cycle transfer reads pend_q, so the incoming entry never clobbers the one being promoted.
  always_comb begin
    load         = bus.sink_sop && lut_hit;
    xfer         = bus.frame_start && pend_valid_q;

    active_d     = xfer ? pend_q : active_q;
    pend_d       = load ? lut_entry : pend_q;
    cfg_valid_d  = cfg_valid_q || xfer;
    pend_valid_d = load ? 1'b1 : (xfer ? 1'b0 : pend_valid_q);

    unsup_err_d  = bus.sink_sop && !lut_hit;
    udf_err_d    = bus.frame_start && !pend_valid_q;
    ovf_err_d    = load && pend_valid_q && !bus.frame_start;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q     <= ENTRY_1200;
      pend_q       <= ENTRY_1200;
      cfg_valid_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      unsup_err_q  <= 1'b0;
      ovf_err_q    <= 1'b0;
      udf_err_q    <= 1'b0;
    end else begin
      active_q     <= active_d;
      pend_q       <= pend_d;
      cfg_valid_q  <= cfg_valid_d;
      pend_valid_q <= pend_valid_d;
      unsup_err_q  <= unsup_err_d;
      ovf_err_q    <= ovf_err_d;
      udf_err_q    <= udf_err_d;
    end
  end

  assign bus.cfg_valid    = cfg_valid_q;
  assign bus.NumOfFactors = active_q.nof;
  assign bus.Nf           = active_q.nf;
  assign bus.Nf_PFA       = active_q.nf_pfa;
  assign bus.q_p          = active_q.q_p;
  assign bus.r_p          = active_q.r_p;
  assign bus.pend_valid   = pend_valid_q;
  assign bus.unsup_err    = unsup_err_q;
  assign bus.ovf_err      = ovf_err_q;
  assign bus.udf_err      = udf_err_q;

endmodule

// File: tb/tb_mrd_cfg_sched.sv
// Directed bench for mrd_cfg_sched: load/transfer, simultaneous events, error pulses and reset.
module tb_mrd_cfg_sched;

  localparam logic [17:0] NF_1200  = {3'd1, 3'd3, 3'd5, 3'd5, 3'd4, 3'd4};
  localparam logic [29:0] PFA_1200 = {10'd3, 10'd25, 10'd16};
  localparam logic [17:0] NF_600   = {3'd1, 3'd3, 3'd5, 3'd5, 3'd2, 3'd4};
  localparam logic [29:0] PFA_600  = {10'd3, 10'd25, 10'd8};
  localparam logic [17:0] NF_12    = {3'd1, 3'd1, 3'd1, 3'd1, 3'd3, 3'd4};

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  mrd_cfg_sched_if bus ();

  mrd_cfg_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the edge; outputs are observed at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sop, input logic [11:0] pts, input logic fs);
    bus.sink_sop    = sop;
    bus.dftpts      = pts;
    bus.frame_start = fs;
  endtask

  task automatic test_reset();
    $display("txn reset then idle");
    drive(1'b0, 12'd0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    total_cnt++;
    if (bus.NumOfFactors !== 3'd5) $display("FAIL reset_nof got=%0d exp=5", bus.NumOfFactors);
    else pass_cnt++;
    total_cnt++;
    if (bus.Nf !== NF_1200) $display("FAIL reset_nf got=%h exp=%h", bus.Nf, NF_1200);
    else pass_cnt++;
    total_cnt++;
    if (bus.Nf_PFA !== PFA_1200) $display("FAIL reset_pfa got=%h exp=%h", bus.Nf_PFA, PFA_1200);
    else pass_cnt++;
    total_cnt++;
    if (bus.q_p !== 10'd3 || bus.r_p !== 10'd17)
      $display("FAIL reset_qr got=%0d/%0d exp=3/17", bus.q_p, bus.r_p);
    else pass_cnt++;
    total_cnt++;
    if (bus.cfg_valid !== 1'b0 || bus.pend_valid !== 1'b0)
      $display("FAIL reset_valids got=%b%b exp=00", bus.cfg_valid, bus.pend_valid);
    else pass_cnt++;
    total_cnt++;
    if ({bus.unsup_err, bus.ovf_err, bus.udf_err} !== 3'b000)
      $display("FAIL reset_errs got=%b%b%b exp=000", bus.unsup_err, bus.ovf_err, bus.udf_err);
    else pass_cnt++;
  endtask

  task automatic test_load_transfer();
    $display("txn load 600 then frame_start after 5 cycles");
    drive(1'b1, 12'd600, 1'b0);
    tick();
    drive(1'b0, 12'd0, 1'b0);
    total_cnt++;
    if (bus.NumOfFactors !== 3'd5 || bus.Nf !== NF_1200 || bus.cfg_valid !== 1'b0)
      $display("FAIL load_active_held got=nf %h cfg %b exp=nf %h cfg 0", bus.Nf, bus.cfg_valid, NF_1200);
    else pass_cnt++;
    for (int i = 1; i <= 5; i++) begin
      total_cnt++;
      if (bus.pend_valid !== 1'b1) $display("FAIL load_pend_t%0d got=%b exp=1", i, bus.pend_valid);
      else pass_cnt++;
      if (i < 5) tick();
    end
    drive(1'b0, 12'd0, 1'b1);
    tick();
    drive(1'b0, 12'd0, 1'b0);
    total_cnt++;
    if (bus.NumOfFactors !== 3'd5 || bus.Nf[5:3] !== 3'd2 || bus.Nf_PFA[9:0] !== 10'd8)
      $display("FAIL xfer_600_fact got=%0d %0d %0d exp=5 2 8", bus.NumOfFactors, bus.Nf[5:3], bus.Nf_PFA[9:0]);
    else pass_cnt++;
    total_cnt++;
    if (bus.q_p !== 10'd2 || bus.r_p !== 10'd67)
      $display("FAIL xfer_600_qr got=%0d/%0d exp=2/67", bus.q_p, bus.r_p);
    else pass_cnt++;
    total_cnt++;
    if (bus.cfg_valid !== 1'b1 || bus.pend_valid !== 1'b0 || bus.udf_err !== 1'b0)
      $display("FAIL xfer_600_flags got=cfg %b pend %b udf %b exp=1 0 0", bus.cfg_valid, bus.pend_valid, bus.udf_err);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    $display("txn load 12, then sop 1200 with frame_start");
    drive(1'b1, 12'd12, 1'b0);
    tick();
    drive(1'b1, 12'd1200, 1'b1);
    tick();
    drive(1'b0, 12'd0, 1'b0);
    total_cnt++;
    if (bus.NumOfFactors !== 3'd2 || bus.Nf !== NF_12)
      $display("FAIL simul_active got=%0d %h exp=2 %h", bus.NumOfFactors, bus.Nf, NF_12);
    else pass_cnt++;
    total_cnt++;
    if (bus.pend_valid !== 1'b1 || bus.ovf_err !== 1'b0 || bus.udf_err !== 1'b0)
      $display("FAIL simul_flags got=pend %b ovf %b udf %b exp=1 0 0", bus.pend_valid, bus.ovf_err, bus.udf_err);
    else pass_cnt++;
    $display("txn frame_start promotes pending 1200");
    drive(1'b0, 12'd0, 1'b1);
    tick();
    drive(1'b0, 12'd0, 1'b0);
    total_cnt++;
    if (bus.NumOfFactors !== 3'd5 || bus.Nf !== NF_1200 || bus.r_p !== 10'd17)
      $display("FAIL simul_pend_1200 got=%0d %h %0d exp=5 %h 17", bus.NumOfFactors, bus.Nf, bus.r_p, NF_1200);
    else pass_cnt++;
    $display("txn sop 12 with frame_start while pending empty");
    drive(1'b1, 12'd12, 1'b1);
    tick();
    drive(1'b0, 12'd0, 1'b0);
    total_cnt++;
    if (bus.udf_err !== 1'b1 || bus.pend_valid !== 1'b1 || bus.ovf_err !== 1'b0 || bus.NumOfFactors !== 3'd5)
      $display("FAIL simul_udf got=udf %b pend %b ovf %b nof %0d exp=1 1 0 5",
               bus.udf_err, bus.pend_valid, bus.ovf_err, bus.NumOfFactors);
    else pass_cnt++;
    drive(1'b0, 12'd0, 1'b1);
    tick();
    drive(1'b0, 12'd0, 1'b0);
    total_cnt++;
    if (bus.NumOfFactors !== 3'd2 || bus.udf_err !== 1'b0 || bus.pend_valid !== 1'b0)
      $display("FAIL simul_udf_load got=nof %0d udf %b pend %b exp=2 0 0", bus.NumOfFactors, bus.udf_err, bus.pend_valid);
    else pass_cnt++;
  endtask

  task automatic test_errors();
    $display("txn unsupported 1000 with frame_start on empty pending");
    drive(1'b1, 12'd1000, 1'b1);
    tick();
    drive(1'b0, 12'd0, 1'b0);
    total_cnt++;
    if (bus.unsup_err !== 1'b1 || bus.udf_err !== 1'b1 || bus.pend_valid !== 1'b0)
      $display("FAIL err_both got=unsup %b udf %b pend %b exp=1 1 0", bus.unsup_err, bus.udf_err, bus.pend_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.NumOfFactors !== 3'd2 || bus.Nf !== NF_12 || bus.cfg_valid !== 1'b1)
      $display("FAIL err_outputs_held got=%0d %h cfg %b exp=2 %h 1", bus.NumOfFactors, bus.Nf, bus.cfg_valid, NF_12);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.unsup_err !== 1'b0 || bus.udf_err !== 1'b0)
      $display("FAIL err_pulse_width got=unsup %b udf %b exp=0 0", bus.unsup_err, bus.udf_err);
    else pass_cnt++;
    $display("txn load 600 then unsupported 1000");
    drive(1'b1, 12'd600, 1'b0);
    tick();
    drive(1'b1, 12'd1000, 1'b0);
    tick();
    drive(1'b0, 12'd0, 1'b0);
    total_cnt++;
    if (bus.unsup_err !== 1'b1 || bus.pend_valid !== 1'b1 || bus.ovf_err !== 1'b0)
      $display("FAIL unsup_pend got=unsup %b pend %b ovf %b exp=1 1 0", bus.unsup_err, bus.pend_valid, bus.ovf_err);
    else pass_cnt++;
    drive(1'b0, 12'd0, 1'b1);
    tick();
    drive(1'b0, 12'd0, 1'b0);
    total_cnt++;
    if (bus.Nf !== NF_600 || bus.Nf_PFA !== PFA_600)
      $display("FAIL unsup_kept_600 got=%h %h exp=%h %h", bus.Nf, bus.Nf_PFA, NF_600, PFA_600);
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    $display("txn load 12 then 600 without frame_start");
    drive(1'b1, 12'd12, 1'b0);
    tick();
    total_cnt++;
    if (bus.ovf_err !== 1'b0) $display("FAIL ovf_first got=%b exp=0", bus.ovf_err);
    else pass_cnt++;
    drive(1'b1, 12'd600, 1'b0);
    tick();
    drive(1'b0, 12'd0, 1'b0);
    total_cnt++;
    if (bus.ovf_err !== 1'b1 || bus.pend_valid !== 1'b1)
      $display("FAIL ovf_second got=ovf %b pend %b exp=1 1", bus.ovf_err, bus.pend_valid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.ovf_err !== 1'b0) $display("FAIL ovf_pulse_width got=%b exp=0", bus.ovf_err);
    else pass_cnt++;
    drive(1'b0, 12'd0, 1'b1);
    tick();
    drive(1'b0, 12'd0, 1'b0);
    total_cnt++;
    if (bus.Nf !== NF_600 || bus.q_p !== 10'd2 || bus.r_p !== 10'd67)
      $display("FAIL ovf_result got=%h %0d %0d exp=%h 2 67", bus.Nf, bus.q_p, bus.r_p, NF_600);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    $display("txn load 12 then rst with frame_start and sop");
    drive(1'b1, 12'd12, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b1, 12'd600, 1'b1);
    tick();
    rst = 1'b0;
    drive(1'b0, 12'd0, 1'b0);
    total_cnt++;
    if (bus.cfg_valid !== 1'b0 || bus.pend_valid !== 1'b0)
      $display("FAIL rst_valids got=cfg %b pend %b exp=0 0", bus.cfg_valid, bus.pend_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.NumOfFactors !== 3'd5 || bus.Nf !== NF_1200 || bus.Nf_PFA !== PFA_1200 ||
        bus.q_p !== 10'd3 || bus.r_p !== 10'd17)
      $display("FAIL rst_entry got=%0d %h %h %0d %0d exp=5 %h %h 3 17",
               bus.NumOfFactors, bus.Nf, bus.Nf_PFA, bus.q_p, bus.r_p, NF_1200, PFA_1200);
    else pass_cnt++;
    total_cnt++;
    if ({bus.unsup_err, bus.ovf_err, bus.udf_err} !== 3'b000)
      $display("FAIL rst_errs got=%b%b%b exp=000", bus.unsup_err, bus.ovf_err, bus.udf_err);
    else pass_cnt++;
    drive(1'b0, 12'd0, 1'b1);
    tick();
    drive(1'b0, 12'd0, 1'b0);
    total_cnt++;
    if (bus.udf_err !== 1'b1 || bus.cfg_valid !== 1'b0)
      $display("FAIL rst_pend_discarded got=udf %b cfg %b exp=1 0", bus.udf_err, bus.cfg_valid);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    drive(1'b0, 12'd0, 1'b0);
    test_reset();
    test_load_transfer();
    test_simultaneous();
    test_errors();
    test_overrun();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mrd_cfg_sched.md
MRD_CFG_SCHED -- requirements
Module: mrd_cfg_sched

Interface
REQ-001 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-002 Ports SHALL be as follows, one per line (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- sink_sop  in  1  start of new input frame
- dftpts  in  12  DFT size; valid only when sink_sop=1
- frame_start  in  1  one-cycle pulse from the top FSM on entry to the compute state
- cfg_valid  out  1  active configuration bank holds a legal entry
- NumOfFactors  out  3  number of DFT stages
- Nf  out  18  six 3-bit radix factors; Nf[0] in bits 2:0
- Nf_PFA  out  30  three 10-bit PFA factors; [0] in bits 9:0
- q_p  out  10  PFA index parameter
- r_p  out  10  PFA index parameter
- pend_valid  out  1  pending bank loaded and not yet consumed
- unsup_err  out  1  one-cycle pulse: dftpts not in table
- ovf_err  out  1  one-cycle pulse: pending bank overwritten before consumption
- udf_err  out  1  one-cycle pulse: frame_start with no pending entry

Function
REQ-003 Size table SHALL be combinational and indexed by dftpts, with exactly these entries (NumOfFactors; Nf[0..5]; Nf_PFA[0..2]; q_p; r_p):
- 1200: 5; 4,4,5,5,3,1; 16,25,3; 3; 17
- 600: 5; 4,2,5,5,3,1; 8,25,3; 2; 67
- 12: 2; 4,3,1,1,1,1; 4,1,3; 1; 1
REQ-004 Storage SHALL be two banks, pending and active, each holding one full table entry.
REQ-005 Pending load: sink_sop=1 at cycle t with a supported dftpts SHALL write the entry into pending and set pend_valid=1 at t+1.
REQ-006 Unsupported size: sink_sop=1 with a dftpts not in the table SHALL leave pending and pend_valid unchanged and pulse unsup_err at t+1.
REQ-007 Transfer: frame_start=1 at cycle t with pend_valid=1 SHALL copy pending to active, set cfg_valid=1 and clear pend_valid, all visible at t+1.
REQ-008 Underrun: frame_start=1 with pend_valid=0 SHALL leave active and cfg_valid unchanged and pulse udf_err at t+1.
REQ-009 Overrun: a supported sink_sop while pend_valid=1 and frame_start=0 SHALL overwrite pending, keep pend_valid=1, and pulse ovf_err at t+1.
REQ-010 Simultaneous sink_sop and frame_start at t SHALL behave as follows:
- the transfer uses the pre-t pending contents;
- the new entry lands in pending with pend_valid=1 at t+1;
- ovf_err SHALL NOT pulse;
- if pend_valid was 0, udf_err pulses and the new entry still loads into pending.
REQ-011 Output sourcing: NumOfFactors, Nf, Nf_PFA, q_p, r_p SHALL be driven directly from active-bank registers and change only on the cycle after a transfer.
REQ-012 Error-pulse width: each error pulse SHALL last exactly one cycle; several errors in the same cycle pulse concurrently.
REQ-013 Once cfg_valid=1, it SHALL remain 1 until rst.

Reset
REQ-014 While rst=1 at a clock edge, the following SHALL take effect at the next cycle:
- cfg_valid=0, pend_valid=0;
- all error pulses 0;
- active and pending banks loaded with the 1200 entry (NumOfFactors=5, Nf=4,4,5,5,3,1, Nf_PFA=16,25,3, q_p=3, r_p=17).
REQ-015 Reset asserted mid-operation SHALL discard any pending entry and override same-cycle sink_sop and frame_start.

Verification
REQ-016 Reset then idle: outputs hold the 1200 entry; cfg_valid=0, pend_valid=0, no error pulse.
REQ-017 Basic load and transfer: sink_sop with dftpts=600 at t0, then frame_start at t0+5 -> pend_valid=1 from t0+1 to t0+5; at t0+6 NumOfFactors=5, Nf[1]=2, Nf_PFA[0]=8, q_p=2, r_p=67, cfg_valid=1, pend_valid=0.
REQ-018 Simultaneous events: pending holds 12, then sink_sop(1200) and frame_start in the same cycle t -> at t+1 active=12 (NumOfFactors=2), pending=1200, pend_valid=1, no ovf_err.
REQ-019 Error cases:
- dftpts=1000 -> unsup_err pulses one cycle, pend_valid unchanged;
- frame_start with empty pending -> udf_err one cycle, outputs unchanged.
REQ-020 Overrun: two supported sink_sop (12, then 600) without frame_start -> ovf_err pulses after the second; the next frame_start yields 600.
REQ-021 Mid-operation reset: rst asserted with pend_valid=1 in the same cycle as frame_start -> next cycle cfg_valid=0, pend_valid=0, outputs hold the 1200 entry.
